// File: rtl/tff_toggle_debouncer.sv
// Debounces a raw asynchronous push-button into a one-cycle toggle request
// for a downstream T flip-flop, and also exports the debounced level and a
// wrapping count of enabled presses.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn_in      raw, bouncy, asynchronous button input
//   en          pulse enable; when 0, t_pulse and press_count are held off
//   t_pulse     one-clock toggle request per accepted, enabled press
//   btn_level   debounced button level
//   press_count wrapping count of accepted, enabled presses
//   state_dbg   current debounce FSM state
module tff_toggle_debouncer #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       en,
    output logic       t_pulse,
    output logic       btn_level,
    output logic [7:0] press_count,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE         = 2'b00;
    localparam logic [1:0] PRESS_WAIT   = 2'b01;
    localparam logic [1:0] PRESSED      = 2'b10;
    localparam logic [1:0] RELEASE_WAIT = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   raw_s;
    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic                   accept;

    assign raw_s     = sync[SYNC_STAGES-1];
    assign state_dbg = state;

    // Only the last stage is used; earlier stages resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    // One counter serves both the press and the release qualification;
    // reaching CNT_MAX always forces a state change, so it cannot overflow.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (raw_s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = PRESSED;
                    accept   = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!raw_s) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 returns to PRESSED without a new pulse.
                if (raw_s) begin
                    state_nx = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            t_pulse     <= 1'b0;
            btn_level   <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            t_pulse   <= accept & en;
            btn_level <= state_nx[1];
            if (accept && en) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/tff_toggle_debouncer.md
Name: tff_toggle_debouncer

Overview:
- Conditions a raw, asynchronous, bouncy push-button into a clean single-cycle toggle request for the downstream T flip-flop's T input.
- Path: synchroniser, then debounce FSM with a stability counter, then a one-cycle press pulse.
- Also exports the debounced button level and an 8-bit wrapping press counter for status display.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in (legal range 2..4).
- DB_CYCLES, 16, consecutive stable synchronised samples required to accept a press or a release (legal range 2..2^CW-1).
- CW, 5, width of the debounce counter; must satisfy DB_CYCLES <= 2^CW-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw button; asynchronous to clk and may bounce.
- en  input  1  pulse enable; when 0, t_pulse and press_count are suppressed while the FSM keeps tracking.
- t_pulse  output  1  one-clock toggle request per accepted press; drives the TFF T input.
- btn_level  output  1  debounced button level.
- press_count  output  8  number of accepted, enabled presses; wraps.
- state_dbg  output  2  current FSM state encoding, for the bench.

Behaviour:
- Reset (rst_n=0, async assert, sync-free release): all synchroniser flops 0, state=IDLE, cnt=0, t_pulse=0, btn_level=0, press_count=0, state_dbg=2'b00.
- Synchroniser: SYNC_STAGES flop chain on btn_in. raw_s is the last stage. Only raw_s is used downstream.
- State encoding: IDLE=00, PRESS_WAIT=01, PRESSED=10, RELEASE_WAIT=11.
- IDLE:
  - raw_s=1 -> PRESS_WAIT, cnt<=0.
- PRESS_WAIT:
  - raw_s=0 -> IDLE, cnt<=0 (bounce rejected).
  - raw_s=1 and cnt<DB_CYCLES-1 -> cnt++.
  - raw_s=1 and cnt==DB_CYCLES-1 -> PRESSED, t_pulse<=en.
- PRESSED:
  - raw_s=0 -> RELEASE_WAIT, cnt<=0.
  - Otherwise hold.
- RELEASE_WAIT:
  - raw_s=1 -> PRESSED, with no new pulse (release bounce absorbed).
  - raw_s=0 and cnt<DB_CYCLES-1 -> cnt++.
  - raw_s=0 and cnt==DB_CYCLES-1 -> IDLE.
- t_pulse:
  - Registered output.
  - High for exactly the one cycle following the PRESS_WAIT->PRESSED transition, and only if en=1 at that transition edge.
  - 0 in every other cycle, so there are never back-to-back pulses.
- Latency: btn_in rises cleanly and stays high; the first edge sampling it is edge 1. t_pulse is high after edge SYNC_STAGES+DB_CYCLES+1 (19 with defaults) and low again after the next edge.
- btn_level: registered. 1 while state is PRESSED or RELEASE_WAIT; 0 in IDLE or PRESS_WAIT.
- press_count: increments by 1 on the same edge that sets t_pulse=1. Modulo 256 (255 -> 0). Unaffected when en=0.
- Press and release counting share a single cnt. cnt saturates logically because the terminal compare forces a state change; it never overflows.
- Reset mid-operation: any state returns to IDLE immediately. An in-flight pulse is dropped and the count is cleared. After release, a button still held must re-qualify the full SYNC_STAGES+DB_CYCLES path before any pulse.
- en toggling: en is sampled only at the PRESS_WAIT->PRESSED edge. A press accepted while en=0 stays accepted: state=PRESSED, btn_level=1, no pulse, and no retroactive pulse when en later rises.

Test Plan:
1. Reset, then btn_in=1 held 40 cycles, en=1 -> t_pulse high exactly one cycle, after edge 19; btn_level=1 from the same edge; press_count=1.
2. Press bounce: btn_in 1 for 5 cycles, 0 for 3, then 1 held, en=1 -> no pulse during bounce; single pulse 19 edges after the final rise; press_count=1.
3. Release bounce: from PRESSED, btn_in 0 for 4 cycles, 1 for 2, 0 held -> no extra t_pulse; btn_level falls 2+16+1 edges after the last fall; state returns to IDLE (00).
4. en=0 during qualification, then 30 cycles of held press -> t_pulse never high, btn_level=1, press_count unchanged; en=1 afterwards with button still held -> still no pulse.
5. Assert rst_n=0 while in PRESS_WAIT with cnt=10, release reset with btn_in still 1 -> outputs 0 during reset; pulse occurs 19 edges after the reset release, not earlier.
6. 257 clean press/release cycles with en=1 -> 257 single-cycle pulses; press_count reads 255 after press 255, 0 after press 256, 1 after press 257.
